// File: rtl/rst_seq.sv
// Staged reset sequencer: releases NumStages active-low resets one by one, DelayCycles apart.
// Optional software reset request enabled by the RST_SEQ_SW_REQ_EN macro.
module rst_seq #(
  parameter int unsigned NumStages   = 3,
  parameter int unsigned DelayCycles = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 test_mode_i,
  input  logic                 req_i,
  output logic                 ack_o,
  output logic [NumStages-1:0] rst_no,
  output logic                 done_o
);

  localparam int unsigned CntW = $clog2(DelayCycles + 1);
  localparam int unsigned IdxW = (NumStages > 1) ? $clog2(NumStages) : 1;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    DONE  = 2'd1,
    SWRST = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NumStages-1:0]  rst_q, rst_d;
  logic                  done_q, done_d;
`ifdef RST_SEQ_SW_REQ_EN
  logic                  ack_q, ack_d;
`else
  logic                  unused_req;
  assign unused_req = req_i;
`endif

  // State and sequencing registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
`ifdef RST_SEQ_SW_REQ_EN
      ack_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
`ifdef RST_SEQ_SW_REQ_EN
      ack_q   <= ack_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
`ifdef RST_SEQ_SW_REQ_EN
    ack_d   = 1'b0;
`endif
    case (state_q)
      HOLD: begin
        if (cnt_q == CntW'(DelayCycles - 1)) begin
          cnt_d = '0;
          idx_d = idx_q + IdxW'(1);
          for (int unsigned i = 0; i < NumStages; i++) begin
            if (idx_q == IdxW'(i)) rst_d[i] = 1'b1;
          end
          if (idx_q == IdxW'(NumStages - 1)) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
`ifdef RST_SEQ_SW_REQ_EN
        if (req_i) begin
          rst_d   = '0;
          done_d  = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = SWRST;
        end
`endif
      end
      SWRST: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = HOLD;
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

  // DFT bypass follows the upstream reset with no clock involvement
  assign rst_no = test_mode_i ? {NumStages{~rst_i}} : rst_q;
  assign done_o = done_q;
`ifdef RST_SEQ_SW_REQ_EN
  assign ack_o  = ack_q;
`else
  assign ack_o  = 1'b0;
`endif

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter NumStages, default 3: number of staged reset outputs, legal range 1..16.
REQ-002 SHALL have parameter DelayCycles, default 4: clock cycles between consecutive releases, legal range 1..65535.
REQ-003 SHALL have port clk_i  input  1: the single clock.
REQ-004 SHALL have port rst_i  input  1: asynchronous active-high reset, already synchronized upstream.
REQ-005 SHALL have port test_mode_i  input  1: DFT bypass select.
REQ-006 SHALL have port req_i  input  1: software reset request, level-sampled.
REQ-007 SHALL have port ack_o  output  1: one-cycle acknowledge of an accepted req_i.
REQ-008 SHALL have port rst_no  output  NumStages: active-low staged resets, one bit per downstream domain.
REQ-009 SHALL have port done_o  output  1: high once all stages are released.
REQ-010 SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-011 SHALL implement three states:
- HOLD: counting the delay before the next release.
- DONE: all stages released.
- SWRST: one-cycle acknowledge state.
REQ-012 SHALL use a counter of width $clog2(DelayCycles+1), cleared on every stage release.
REQ-013 In HOLD, SHALL increment the counter each edge; at the edge where counter equals DelayCycles-1, SHALL set rst_no[next] to 1, clear the counter and advance the stage index.
REQ-014 Stage k (0-based) SHALL release at rising edge (k+1)*DelayCycles after rst_i deassertion, counting the first edge as 1.
REQ-015 SHALL release stages strictly in ascending index order, with at most one release per edge.
REQ-016 When the last stage releases, SHALL set done_o to 1 at the same edge and enter DONE.
REQ-017 With DelayCycles=1, SHALL release one stage per edge starting at the first edge after deassertion.
REQ-018 Once a stage is released, it SHALL stay released until rst_i or an accepted req_i.
REQ-019 When test_mode_i=1, SHALL drive every rst_no bit combinationally to ~rst_i; internal sequencing SHALL continue unaffected.
REQ-020 done_o and ack_o SHALL be registered outputs and SHALL NOT depend on test_mode_i.
REQ-021 SHALL ignore req_i in every state except DONE.

Reset
REQ-022 While rst_i=1, SHALL hold rst_no all 0, done_o 0, ack_o 0, counter 0, stage index 0 and state HOLD, independent of clk_i.
REQ-023 Assertion of rst_i mid-sequence, in DONE or in SWRST SHALL immediately force REQ-022 values; sequencing SHALL restart from stage 0 after deassertion.
REQ-024 rst_i deassertion SHALL take effect on the first rising clk_i edge after it.

Configuration
REQ-025 Macro RST_SEQ_SW_REQ_EN SHALL gate the software-reset feature.
REQ-026 With RST_SEQ_SW_REQ_EN defined, req_i=1 sampled in DONE SHALL, at that edge:
- drive all rst_no to 0 and done_o to 0;
- set ack_o to 1 and enter SWRST.
REQ-027 On the following edge, SWRST SHALL clear ack_o, enter HOLD with counter 0, and rerun REQ-013..REQ-016.
REQ-028 A req_i still high when DONE is re-reached SHALL start a new cycle.
REQ-029 With RST_SEQ_SW_REQ_EN undefined, SHALL ignore req_i, tie ack_o to 0, and never reach SWRST.

Verification
All scenarios use NumStages=3 and DelayCycles=4.
REQ-030 Basic sequence:
- stimulus: deassert rst_i;
- required response: rst_no 3'b000 -> 3'b001 at edge 4, 3'b011 at edge 8, 3'b111 at edge 12, with done_o=1 at edge 12.
REQ-031 Mid-sequence reset:
- stimulus: assert rst_i at edge 6;
- required response: rst_no=3'b000 and done_o=0 immediately; after deassertion, the first release is 4 edges later.
REQ-032 Test mode:
- stimulus: test_mode_i=1, toggle rst_i;
- required response: rst_no tracks {3{~rst_i}} with zero cycles of latency; done_o follows the normal sequence.
REQ-033 Software reset (macro defined):
- stimulus: in DONE, pulse req_i for 1 cycle;
- required response: ack_o high for exactly 1 cycle, rst_no=3'b000 at the same edge, re-release at +5/+9/+13 edges.
REQ-034 Early request:
- stimulus: req_i=1 held from deassertion;
- required response: no acknowledge before done_o; ack_o at the edge after edge 12, then the sequence repeats.
REQ-035 Macro undefined:
- stimulus: req_i=1 in DONE;
- required response: ack_o stays 0, rst_no stays 3'b111, done_o stays 1.
